// File: rtl/ips_nav_sequencer.sv
// ips_nav_sequencer
// Line-follow sequencer between three IPS line sensors and a dual H-bridge.
// Sensors are synchronised and debounced into a filtered vector {L,M,R};
// an FSM follows the line, reverses when the line is lost, pivots in the
// last known turn direction, and gives up into FAULT if nothing is found.
// Direction pins and PWM enables are all registered.

module ips_nav_sequencer #(
    parameter int DEB_CYCLES    = 4,
    parameter int PWM_BITS      = 8,
    parameter int DUTY_FWD      = 200,
    parameter int DUTY_TURN     = 140,
    parameter int LOST_CYCLES   = 1000,
    parameter int SEARCH_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       L,
    input  logic       M,
    input  logic       R,
    output logic       IN1,
    output logic       IN2,
    output logic       IN3,
    output logic       IN4,
    output logic       ENA,
    output logic       ENB,
    output logic [2:0] state,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FOLLOW = 3'd1,
        ST_LOST   = 3'd2,
        ST_SEARCH = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam int DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam int TMR_MAXC = (LOST_CYCLES > SEARCH_CYCLES) ? LOST_CYCLES : SEARCH_CYCLES;
    localparam int TMR_W    = (TMR_MAXC > 1) ? $clog2(TMR_MAXC) : 1;

    // Sensor path: two sync stages, debounce candidate, accepted vector
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       cand;
    logic [2:0]       filt;
    logic [DEB_W-1:0] stab_cnt;

    // Sequencer state
    state_t           cur;
    dir_t             last_dir;
    logic [TMR_W-1:0] timer;

    // Drive decode (combinational, registered below)
    logic                drive_on;
    logic                dir_l;
    logic                dir_r;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] pwm_cnt;

    // Vector classes used by the FSM: no line, or split line under L and R
    logic line_lost;
    logic left_vec;
    logic right_vec;

    assign line_lost = (filt == 3'b000) || (filt == 3'b101);
    assign left_vec  = (filt == 3'b100) || (filt == 3'b110);
    assign right_vec = (filt == 3'b001) || (filt == 3'b011);

    assign state = cur;

    // Two-flop synchroniser, then accept the candidate once it has been seen
    // for DEB_CYCLES consecutive samples; any change restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state always uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            sync1    <= 3'b000;
            sync2    <= 3'b000;
            cand     <= 3'b000;
            filt     <= 3'b000;
            stab_cnt <= '0;
        end else begin
            sync1 <= {L, M, R};
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand     <= sync2;
                stab_cnt <= DEB_W'(1);
                if (DEB_CYCLES == 1) begin
                    filt <= sync2;
                end
            end else if (stab_cnt != DEB_W'(DEB_CYCLES)) begin
                stab_cnt <= stab_cnt + DEB_W'(1);
                if (stab_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                    filt <= cand;
                end
            end
        end
    end

    // Sequencer: stop wins everywhere; timer runs only in LOST and SEARCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= ST_IDLE;
            last_dir <= DIR_LEFT;
            timer    <= '0;
        end else if (stop) begin
            cur   <= ST_IDLE;
            timer <= '0;
        end else begin
            case (cur)
                ST_IDLE: begin
                    timer <= '0;
                    if (start) begin
                        cur <= ST_FOLLOW;
                    end
                end
                ST_FOLLOW: begin
                    timer <= '0;
                    if (line_lost) begin
                        cur <= ST_LOST;
                    end else if (left_vec) begin
                        last_dir <= DIR_LEFT;
                    end else if (right_vec) begin
                        last_dir <= DIR_RIGHT;
                    end
                end
                ST_LOST: begin
                    if (!line_lost) begin
                        cur   <= ST_FOLLOW;
                        timer <= '0;
                    end else if (timer == TMR_W'(LOST_CYCLES - 1)) begin
                        cur   <= ST_SEARCH;
                        timer <= '0;
                    end else if (timer != '1) begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_SEARCH: begin
                    if (filt != 3'b000) begin
                        cur   <= ST_FOLLOW;
                        timer <= '0;
                    end else if (timer == TMR_W'(SEARCH_CYCLES - 1)) begin
                        cur   <= ST_FAULT;
                        timer <= '0;
                    end else if (timer != '1) begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_FAULT: begin
                    timer <= '0;
                end
                default: begin
                    cur   <= ST_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // Map state and filtered vector to bridge direction and duty.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        drive_on = 1'b0;
        dir_l    = 1'b0;
        dir_r    = 1'b0;
        duty     = '0;
        case (cur)
            ST_FOLLOW: begin
                drive_on = 1'b1;
                case (filt)
                    3'b010, 3'b111: begin
                        dir_l = 1'b1;
                        dir_r = 1'b1;
                        duty  = PWM_BITS'(DUTY_FWD);
                    end
                    3'b100, 3'b110: begin
                        dir_l = 1'b1;
                        duty  = PWM_BITS'(DUTY_TURN);
                    end
                    3'b001, 3'b011: begin
                        dir_r = 1'b1;
                        duty  = PWM_BITS'(DUTY_TURN);
                    end
                    default: begin
                        // line just vanished; reverse for the cycle before LOST
                        duty = PWM_BITS'(DUTY_TURN);
                    end
                endcase
            end
            ST_LOST: begin
                drive_on = 1'b1;
                duty     = PWM_BITS'(DUTY_TURN);
            end
            ST_SEARCH: begin
                drive_on = 1'b1;
                dir_l    = (last_dir == DIR_LEFT);
                dir_r    = (last_dir == DIR_RIGHT);
                duty     = PWM_BITS'(DUTY_TURN);
            end
            default: begin
                drive_on = 1'b0;
            end
        endcase
    end

    // Registered motor outputs and free-running PWM compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IN1     <= 1'b0;
            IN2     <= 1'b0;
            IN3     <= 1'b0;
            IN4     <= 1'b0;
            ENA     <= 1'b0;
            ENB     <= 1'b0;
            fault   <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            IN1     <= drive_on & dir_l;
            IN2     <= drive_on & ~dir_l;
            IN3     <= drive_on & dir_r;
            IN4     <= drive_on & ~dir_r;
            ENA     <= (pwm_cnt < duty);
            ENB     <= (pwm_cnt < duty);
            fault   <= (cur == ST_FAULT);
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

endmodule
